// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Pipeline sequencing controller for the 5-stage RV32 core. It sits beside the
// ID stage. It compares the ID-stage instruction's source registers with the
// ID/EX destination and drives the PC / IF-ID write enables, the IF/ID flush
// and the ID/EX bubble. It handles three events:
//   * load-use hazards : LOAD_STALL_CYCLES bubbles per hazard
//   * taken BEQ in ID  : one-cycle IF/ID flush
//   * data-memory wait : the whole pipe is frozen while dmem_busy_i is high
//
// All control outputs are combinational from the state and the current inputs,
// so a stall takes effect in the same cycle the hazard is seen.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (1..7)
//   MEM_TIMEOUT        wait-counter value that sets mem_timeout_o (1..255)
//
// Optional feature
//   HAZARD_PERF_CNT_EN  when defined, builds two saturating 32-bit counters:
//                       stall cycles (pc_write_o==0) and flush cycles
//                       (if_id_flush_o==1), both counted outside reset.
//                       When undefined, both ports read 0 and no counter
//                       flops exist.
//
// Ports
//   clk_i            in   1   clock, rising edge
//   rst_i            in   1   synchronous reset, active-low
//   id_instr_i       in   32  instruction held in IF/ID
//   id_ex_memread_i  in   1   ID/EX holds a load
//   id_ex_rd_i       in   5   ID/EX destination register
//   branch_taken_i   in   1   BEQ in ID resolved taken
//   dmem_busy_i      in   1   data memory not ready this cycle
//   pc_write_o       out  1   PC update enable
//   if_id_write_o    out  1   IF/ID write enable
//   if_id_flush_o    out  1   zero IF/ID on next edge
//   id_ex_bubble_o   out  1   force ID/EX control bits to zero
//   pipe_hold_o      out  1   freeze ID/EX, EX/MEM, MEM/WB
//   mem_timeout_o    out  1   sticky memory-wait timeout flag
//   stall_cycles_o   out  32  perf counter: stalled cycles
//   flush_count_o    out  32  perf counter: flush cycles
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] id_instr_i,
    input  logic        id_ex_memread_i,
    input  logic [4:0]  id_ex_rd_i,
    input  logic        branch_taken_i,
    input  logic        dmem_busy_i,
    output logic        pc_write_o,
    output logic        if_id_write_o,
    output logic        if_id_flush_o,
    output logic        id_ex_bubble_o,
    output logic        pipe_hold_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // The first bubble is issued from RUN. The rest are counted down in
    // LDSTALL, so the counter is loaded with one less than the total.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LIM  = 8'(MEM_TIMEOUT);
    localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [2:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q;
    logic       timeout_set;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use_hazard;

    assign opcode = id_instr_i[6:0];
    assign rs1    = id_instr_i[19:15];
    assign rs2    = id_instr_i[24:20];

    // Only the opcode and register fields matter here. The remaining bits are
    // folded into a sink so the unused input bits are visible as intentional.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{id_instr_i[31:25], id_instr_i[14:7]};

    // Only opcodes that really read a source field are allowed to raise a
    // hazard. For example, the rs2 field of an I-type is part of the immediate.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OP_REG:    begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_IMM:    begin rs1_used = 1'b1;                  end
            OP_LOAD:   begin rs1_used = 1'b1;                  end
            OP_STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            default:   begin rs1_used = 1'b0; rs2_used = 1'b0; end
        endcase
    end

    // x0 is hard-wired to zero, so a load into x0 never creates a dependency.
    assign load_use_hazard = id_ex_memread_i
                          && (id_ex_rd_i != 5'd0)
                          && ((rs1_used && (id_ex_rd_i == rs1))
                           || (rs2_used && (id_ex_rd_i == rs2)));

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // Memory busy has priority over everything in every state.
    // MEMWAIT with busy low behaves exactly like RUN, so the release cycle
    // already reflects any pending hazard or taken branch.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d        = state_q;
        stall_cnt_d    = 3'd0;
        wait_cnt_d     = 8'd0;
        timeout_set    = 1'b0;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_hold_o    = 1'b0;

        if (dmem_busy_i) begin
            // Freeze the whole pipe. A pending load-use countdown is dropped.
            // Once memory is ready, the hazard is evaluated again.
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            pipe_hold_o   = 1'b1;
            state_d       = ST_MEMWAIT;
            if (state_q == ST_MEMWAIT) begin
                wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
            end else begin
                wait_cnt_d = 8'd1;
            end
            // The flag is set when the counter is loaded with the limit, so
            // it reads high in the MEMWAIT cycle whose count equals the limit.
            timeout_set = (wait_cnt_d >= TIMEOUT_LIM);
        end else begin
            case (state_q)
                ST_LDSTALL: begin
                    // While a countdown is running, branches are ignored.
                    pc_write_o     = 1'b0;
                    if_id_write_o  = 1'b0;
                    id_ex_bubble_o = 1'b1;
                    if (stall_cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 3'd1;
                    end
                end

                default: begin
                    // ST_RUN, or ST_MEMWAIT in the cycle memory becomes ready.
                    state_d = ST_RUN;
                    if (load_use_hazard) begin
                        pc_write_o     = 1'b0;
                        if_id_write_o  = 1'b0;
                        id_ex_bubble_o = 1'b1;
                        if (MULTI_STALL) begin
                            state_d     = ST_LDSTALL;
                            stall_cnt_d = STALL_RELOAD;
                        end
                    end else if (branch_taken_i) begin
                        if_id_flush_o = 1'b1;
                        pc_write_o    = 1'b1;
                    end
                end
            endcase
        end

        // While reset is held, the pipe is flushed and bubbled and nothing
        // advances. No stall outlives the reset.
        if (!rst_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            pipe_hold_o    = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= ST_RUN;
            stall_cnt_q   <= 3'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_q | timeout_set;
        end
    end

    assign mem_timeout_o = mem_timeout_q;

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // The reset branch has priority, so cycles in reset are never counted even
    // though the forced outputs show pc_write_o=0 and if_id_flush_o=1.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (!pc_write_o && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (if_id_flush_o && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_controller
//
// Two instances run in lock-step on the same inputs:
//   u_a : default parameters (1 bubble per hazard, timeout at 255)
//   u_b : LOAD_STALL_CYCLES=3, MEM_TIMEOUT=4
//
// A reference model predicts every output of both instances each cycle.
// It tracks the bubbles still owed, the length of the current busy run, the
// sticky timeout flag and the perf counts. A directed prologue comes first,
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] id_instr;
    logic        memread;
    logic [4:0]  ex_rd;
    logic        br_taken;
    logic        dmem_busy;

    logic        a_pc, a_ifw, a_fl, a_bub, a_hold, a_tmo;
    logic [31:0] a_sc, a_fc;
    logic        b_pc, b_ifw, b_fl, b_bub, b_hold, b_tmo;
    logic [31:0] b_sc, b_fc;

    always #5 clk = ~clk;

    hazard_stall_controller u_a (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .id_instr_i      (id_instr),
        .id_ex_memread_i (memread),
        .id_ex_rd_i      (ex_rd),
        .branch_taken_i  (br_taken),
        .dmem_busy_i     (dmem_busy),
        .pc_write_o      (a_pc),
        .if_id_write_o   (a_ifw),
        .if_id_flush_o   (a_fl),
        .id_ex_bubble_o  (a_bub),
        .pipe_hold_o     (a_hold),
        .mem_timeout_o   (a_tmo),
        .stall_cycles_o  (a_sc),
        .flush_count_o   (a_fc)
    );

    hazard_stall_controller #(
        .LOAD_STALL_CYCLES (3),
        .MEM_TIMEOUT       (4)
    ) u_b (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .id_instr_i      (id_instr),
        .id_ex_memread_i (memread),
        .id_ex_rd_i      (ex_rd),
        .branch_taken_i  (br_taken),
        .dmem_busy_i     (dmem_busy),
        .pc_write_o      (b_pc),
        .if_id_write_o   (b_ifw),
        .if_id_flush_o   (b_fl),
        .id_ex_bubble_o  (b_bub),
        .pipe_hold_o     (b_hold),
        .mem_timeout_o   (b_tmo),
        .stall_cycles_o  (b_sc),
        .flush_count_o   (b_fc)
    );

    // ---------------------------------------------------------------------
    // Reference model state
    // ---------------------------------------------------------------------
    int unsigned     p_stalls [2] = '{1, 3};
    int unsigned     p_tmo    [2] = '{255, 4};
    int unsigned     owed     [2];  // bubbles still owed after this cycle
    int unsigned     busy_run [2];  // consecutive busy cycles so far
    bit              tmo      [2];
    longint unsigned n_stall  [2];
    longint unsigned n_flush  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] ADD_X6_X5_X1 = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_X6_X0_X0 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADDI_X6_X7_5 = {12'd5, 5'd7, 3'd0, 5'd6, 7'b0010011};
    localparam logic [31:0] BEQ_X1_X2    = {7'd0, 5'd2, 5'd1, 3'd0, 5'd8, 7'b1100011};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hazard(input logic [31:0] ins, input logic mr, input logic [4:0] d);
        logic [6:0] op;
        bit r1, r2;
        op = ins[6:0];
        r1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return mr && (d != 5'd0) && ((r1 && d == ins[19:15]) || (r2 && d == ins[24:20]));
    endfunction

    function automatic logic [31:0] sat32(input longint unsigned v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    // One clock cycle: apply inputs, check both instances, then advance the model.
    // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}.
    task automatic step(input logic r, input logic [31:0] ins, input logic mr,
                        input logic [4:0] d, input logic b, input logic bz);
        logic [4:0]  e;
        logic [4:0]  o;
        logic [4:0]  ex [2];
        logic        o_tmo;
        logic [31:0] o_sc, o_fc;
        bit          hz;

        @(negedge clk);
        rst_i     = r;
        id_instr  = ins;
        memread   = mr;
        ex_rd     = d;
        br_taken  = b;
        dmem_busy = bz;
        #1;
        hz = hazard(ins, mr, d);
        for (int k = 0; k < 2; k++) begin
            if (!r)                        e = 5'b00110;
            else if (bz)                   e = 5'b00001;
            else if (owed[k] > 0 || hz)    e = 5'b00010;
            else if (b)                    e = 5'b11100;
            else                           e = 5'b11000;
            ex[k] = e;
            if (k == 0) begin
                o = {a_pc, a_ifw, a_fl, a_bub, a_hold}; o_tmo = a_tmo; o_sc = a_sc; o_fc = a_fc;
            end else begin
                o = {b_pc, b_ifw, b_fl, b_bub, b_hold}; o_tmo = b_tmo; o_sc = b_sc; o_fc = b_fc;
            end
            check($sformatf("c%0d u%0d ctl{pc,ifw,fl,bub,hold}", cyc, k), {27'd0, o}, {27'd0, e});
            check($sformatf("c%0d u%0d mem_timeout", cyc, k), {31'd0, o_tmo}, {31'd0, tmo[k]});
`ifdef HAZARD_PERF_CNT_EN
            check($sformatf("c%0d u%0d stall_cycles", cyc, k), o_sc, sat32(n_stall[k]));
            check($sformatf("c%0d u%0d flush_count", cyc, k), o_fc, sat32(n_flush[k]));
`else
            check($sformatf("c%0d u%0d stall_cycles", cyc, k), o_sc, 32'd0);
            check($sformatf("c%0d u%0d flush_count", cyc, k), o_fc, 32'd0);
`endif
        end

        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                owed[k] = 0; busy_run[k] = 0; tmo[k] = 1'b0;
                n_stall[k] = 0; n_flush[k] = 0;
            end else begin
                if (!ex[k][4]) n_stall[k]++;
                if (ex[k][2])  n_flush[k]++;
                if (bz) begin
                    busy_run[k]++;
                    owed[k] = 0;
                    if (((busy_run[k] > 255) ? 255 : busy_run[k]) >= p_tmo[k]) tmo[k] = 1'b1;
                end else begin
                    busy_run[k] = 0;
                    if (owed[k] > 0) owed[k]--;
                    else if (hz)     owed[k] = p_stalls[k] - 1;
                end
            end
        end
        cyc++;
    endtask

    logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b1101111, 7'b1110011};

    initial begin
        int burst;
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0; busy_run[k] = 0; tmo[k] = 1'b0; n_stall[k] = 0; n_flush[k] = 0;
        end
        rst_i = 1'b0; id_instr = NOP; memread = 1'b0; ex_rd = 5'd0;
        br_taken = 1'b0; dmem_busy = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state with outputs forced.
        step(0, NOP, 0, 5'd0, 0, 0);
        step(1, NOP, 0, 5'd0, 0, 0);

        // LW x5 then ADD x6,x5,x1: one bubble on u_a, three on u_b.
        step(1, ADD_X6_X5_X1, 1, 5'd5, 0, 0);
        repeat (4) step(1, NOP, 0, 5'd0, 0, 0);

        // No hazard through x0 or through the immediate field of ADDI.
        step(1, ADD_X6_X0_X0, 1, 5'd0, 0, 0);
        step(1, ADDI_X6_X7_5, 1, 5'd5, 0, 0);

        // Taken BEQ: a single flush cycle.
        step(1, BEQ_X1_X2, 0, 5'd5, 1, 0);
        step(1, NOP, 0, 5'd0, 0, 0);

        // Hazard under a 3-cycle memory wait, then the load-use stall.
        repeat (3) step(1, ADD_X6_X5_X1, 1, 5'd5, 0, 1);
        step(1, ADD_X6_X5_X1, 1, 5'd5, 0, 0);
        repeat (4) step(1, NOP, 0, 5'd0, 0, 0);

        // Six busy cycles: u_b times out in its 4th MEMWAIT cycle and stays set.
        repeat (6) step(1, NOP, 0, 5'd0, 0, 1);
        repeat (3) step(1, NOP, 0, 5'd0, 0, 0);
        step(0, NOP, 0, 5'd0, 0, 0);
        step(1, NOP, 0, 5'd0, 0, 0);

        // Reset in the 2nd stall cycle of u_b aborts the stall.
        step(1, ADD_X6_X5_X1, 1, 5'd5, 0, 0);
        step(0, ADD_X6_X5_X1, 1, 5'd5, 0, 0);
        repeat (2) step(1, NOP, 0, 5'd0, 0, 0);

        // Randomized traffic with narrow register ranges so hazards are common.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            logic        bz;
            ins        = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 7)];
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            if (burst == 0 && $urandom_range(0, 12) == 0) burst = $urandom_range(1, 8);
            bz = (burst > 0);
            if (burst > 0) burst--;
            step(($urandom_range(0, 99) != 0), ins, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), bz);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
